// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   aluop_t        : 5-bit ALU operation code as produced by the control unit
//   ALUOP_*        : M-extension encodings (must match the control unit)
//   ST_*           : muldiv_unit FSM state encodings
//   is_m_op()      : op is any of MUL..REMU
//   is_mul_op()    : op is one of MUL/MULH/MULHSU/MULHU
package muldiv_pkg;

  typedef logic [4:0] aluop_t;

  localparam aluop_t ALUOP_MUL    = 5'b01011;
  localparam aluop_t ALUOP_MULH   = 5'b01100;
  localparam aluop_t ALUOP_MULHSU = 5'b01101;
  localparam aluop_t ALUOP_MULHU  = 5'b01110;
  localparam aluop_t ALUOP_DIV    = 5'b01111;
  localparam aluop_t ALUOP_DIVU   = 5'b10000;
  localparam aluop_t ALUOP_REM    = 5'b10001;
  localparam aluop_t ALUOP_REMU   = 5'b10010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_m_op(aluop_t op);
    return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
  endfunction

  function automatic logic is_mul_op(aluop_t op);
    return (op >= ALUOP_MUL) && (op <= ALUOP_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: unsigned radix-2 restoring divider, one quotient bit per cycle.
//   clk, reset  : clock, synchronous active-high reset (also used to abort)
//   start       : load dividend/divisor and begin XLEN iterations
//   dividend    : unsigned dividend
//   divisor     : unsigned divisor (non-zero; zero is handled by the caller)
//   busy        : iterations in progress
//   done        : this cycle performs the final iteration
//   quotient    : quotient after this cycle's iteration (final when done=1)
//   remainder   : remainder after this cycle's iteration (final when done=1)
module muldiv_div_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic             busy_r;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dsor;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             fits;
  logic [XLEN-1:0]  quo_nxt;
  logic [XLEN-1:0]  rem_nxt;

  // quo doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter from the LSB.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, dsor};
    fits    = ~diff[XLEN];
    rem_nxt = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt = {quo[XLEN-2:0], fits};
  end

  assign busy      = busy_r;
  assign done      = busy_r && (cnt == CNT_W'(XLEN - 1));
  // Exposing the post-step values lets the caller capture the result on the
  // same edge as the last iteration, saving a cycle.
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dsor   <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt    <= '0;
      quo    <= dividend;
      rem    <= '0;
      dsor   <= divisor;
    end else if (busy_r) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      if (done) begin
        busy_r <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execution unit beside the EX-stage ALU.
//   clk, reset          : clock, synchronous active-high reset
//   start, aluop        : request and M-extension op code (accepted when ready)
//   operand1, operand2  : rs1 / rs2 values
//   flush               : abort any in-flight op, return to IDLE
//   ready               : can accept (IDLE and no flush)
//   busy                : not IDLE; stalls the front of the pipeline
//   valid_out           : one-cycle pulse, result valid
//   result              : last completed result, held until the next pulse
//
// state   | meaning
// IDLE    | waiting for an M-op
// MUL     | full product formed from latched operands, result captured
// DIV     | divider core iterating on operand magnitudes
// DONE    | result valid, valid_out high for this cycle
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      aluop,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  aluop_t          op_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] result_r;

  // Request decode on the live inputs.
  logic            accept;
  logic            in_sdiv;
  logic            in_rem;
  logic            div_special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_start;

  always_comb begin
    in_sdiv     = (aluop == ALUOP_DIV) || (aluop == ALUOP_REM);
    in_rem      = (aluop == ALUOP_REM) || (aluop == ALUOP_REMU);
    accept      = start && ready && is_m_op(aluop);
    div_special = (operand2 == '0) ||
                  (in_sdiv && (operand1 == XMIN) && (operand2 == '1));
    if (operand2 == '0)
      special_res = in_rem ? operand1 : '1;
    else
      special_res = in_rem ? '0 : XMIN;
    mag1      = (in_sdiv && operand1[XLEN-1]) ? -operand1 : operand1;
    mag2      = (in_sdiv && operand2[XLEN-1]) ? -operand2 : operand2;
    div_start = accept && !is_mul_op(aluop) && !div_special;
  end

  // Sign-extending both operands to 2*XLEN makes one unsigned multiply
  // correct modulo 2**(2*XLEN) for all three signedness combinations.
  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    sa      = (op_r == ALUOP_MULH) || (op_r == ALUOP_MULHSU);
    sb      = (op_r == ALUOP_MULH);
    a_ext   = {{XLEN{sa & a_r[XLEN-1]}}, a_r};
    b_ext   = {{XLEN{sb & b_r[XLEN-1]}}, b_r};
    product = a_ext * b_ext;
    mul_res = (op_r == ALUOP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  logic            div_busy;
  logic            div_fin;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic            div_done;
  logic [XLEN-1:0] div_res;

  muldiv_div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk       (clk),
    .reset     (reset | flush),
    .start     (div_start),
    .dividend  (mag1),
    .divisor   (mag2),
    .busy      (div_busy),
    .done      (div_fin),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    div_done = div_fin && div_busy;
    if ((op_r == ALUOP_REM) || (op_r == ALUOP_REMU))
      div_res = neg_r ? -div_rem : div_rem;
    else
      div_res = neg_q ? -div_quo : div_quo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_r     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r  <= aluop;
            a_r   <= operand1;
            b_r   <= operand2;
            neg_q <= in_sdiv && (operand1[XLEN-1] ^ operand2[XLEN-1]);
            neg_r <= in_sdiv && operand1[XLEN-1];
            if (is_mul_op(aluop)) begin
              state <= ST_MUL;
            end else if (div_special) begin
              result_r <= special_res;
              state    <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_r <= mul_res;
          state    <= ST_DONE;
        end
        ST_DIV: begin
          if (div_done) begin
            result_r <= div_res;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready     = (state == ST_IDLE) && !flush;
  assign busy      = (state != ST_IDLE);
  assign valid_out = (state == ST_DONE);
  assign result    = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with a queue scoreboard.
// Stimulus pushes expected result/latency; a negedge monitor pops on valid_out.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  aluop;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        valid_out;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .aluop     (aluop),
    .operand1  (operand1),
    .operand2  (operand2),
    .flush     (flush),
    .ready     (ready),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result)
  );

  localparam logic [4:0] OP_MUL    = 5'b01011;
  localparam logic [4:0] OP_MULH   = 5'b01100;
  localparam logic [4:0] OP_MULHSU = 5'b01101;
  localparam logic [4:0] OP_MULHU  = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_DIVU   = 5'b10000;
  localparam logic [4:0] OP_REM    = 5'b10001;
  localparam logic [4:0] OP_REMU   = 5'b10010;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lat_obs;
  logic [31:0] last_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result %h with no op pending", result);
      end else begin
        e = sb_q.pop_front();
        lat_obs = cyc - e.acc + 1;
        checks += 2;
        if (result !== e.res) begin
          errors++;
          $display("FAIL %s_result: got %h expected %h", e.name, result, e.res);
        end
        if (lat_obs != e.lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d expected %0d", e.name, lat_obs, e.lat);
        end
      end
    end
  end

  task automatic run_op(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, int lat, bit chk_busy);
    exp_t t;
    bit   busy_bad;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    aluop    = op;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    t.name = name; t.res = exp; t.lat = lat; t.acc = cyc + 1;
    sb_q.push_back(t);
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_bad = 1'b0;
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() != 0 && !busy) busy_bad = 1'b1;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no valid_out expected one within 60 cycles", name);
      sb_q.delete();
    end
    if (chk_busy) chk({name, "_busy_held"}, {31'd0, busy_bad}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    aluop = 5'd0; operand1 = '0; operand2 = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_valid",  {31'd0, valid_out}, 32'd0);
    chk("rst_ready",  {31'd0, ready}, 32'd1);

    run_op("mul",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1);
    run_op("mulh",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2, 1);
    run_op("mulhu",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1);
    run_op("mulhsu",  OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 2, 1);
    run_op("div",     OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33, 1);
    run_op("rem",     OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33, 1);
    run_op("divu",    OP_DIVU,   32'd100,      32'd7,        32'd14,       33, 1);
    run_op("remu",    OP_REMU,   32'd100,      32'd7,        32'd2,        33, 1);
    run_op("div_nd",  OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33, 1);
    run_op("rem_nd",  OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33, 1);
    run_op("div_z",   OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1, 1);
    run_op("remu_z",  OP_REMU,   32'd5,        32'd0,        32'd5,        1, 1);
    run_op("div_ovf", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    run_op("rem_ovf", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1);

    // Flush at cycle 10 of a divide: no valid_out (monitor flags any), idle next cycle.
    @(negedge clk);
    aluop = OP_DIVU; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy",   {31'd0, busy}, 32'd0);
    chk("flush_ready",  {31'd0, ready}, 32'd1);
    chk("flush_result", result, last_exp);
    repeat (40) @(negedge clk);
    chk("flush_result_held", result, last_exp);
    run_op("mul_after_flush", OP_MUL, 32'd12345, 32'd1000, 32'd12345000, 2, 1);

    // Flush and start in the same idle cycle: flush wins.
    @(negedge clk);
    aluop = OP_MUL; operand1 = 32'd3; operand2 = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset mid-divide discards the op.
    @(negedge clk);
    aluop = OP_DIV; operand1 = 32'd999; operand2 = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
    chk("rst_mid_ready",  {31'd0, ready}, 32'd1);
    chk("rst_mid_result", result, 32'd0);
    repeat (40) @(negedge clk);
    last_exp = 32'd0;

    // Non-M op with start is ignored.
    @(negedge clk);
    aluop = 5'b00001; operand1 = 32'd6; operand2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("nonm_busy",  {31'd0, busy}, 32'd0);
    chk("nonm_ready", {31'd0, ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("nonm_result", result, last_exp);

    run_op("mul_last", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
